// File: rtl/alu4_seq_ctrl.sv
//==============================================================================
// alu4_seq_ctrl : runs 16-bit ALU ops on a 4-bit slice, one nibble per cycle
// Revision 1.0
//==============================================================================
`default_nettype none

module alu4_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [4*NIBBLES-1:0]   req_a,
  input  logic [4*NIBBLES-1:0]   req_b,
  input  logic                   req_cin,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [4*NIBBLES-1:0]   resp_result,
  output logic                   resp_carry,
  output logic                   resp_overflow,
  output logic                   resp_zero,
  output logic                   resp_flag,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [2:0]             alu_c,
  output logic                   alu_cin,
  input  logic [3:0]             alu_result,
  input  logic                   alu_carry,
  input  logic                   alu_overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic           r_carry;
  logic           r_zacc;

  logic           w_req_inv, w_req_arith, w_inv, w_arith, w_last, w_nib_zero;
  logic [3:0]     w_a_nib, w_b_nib;

  // sub and compares run as a + ~b + 1 on the slice's adder so carry chains cleanly
  assign w_req_inv   = (req_op == 3'b001) || (req_op[2:1] == 2'b11);
  assign w_req_arith = (req_op == 3'b000) || w_req_inv;
  assign w_inv       = (r_op == 3'b001) || (r_op[2:1] == 2'b11);
  assign w_arith     = (r_op == 3'b000) || w_inv;
  assign w_last      = (r_cnt == CW'(NIBBLES - 1));
  assign w_nib_zero  = (alu_result == 4'd0);

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);

  always_comb begin
    w_a_nib = 4'd0;
    w_b_nib = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_c    = 3'd0;
    alu_cin  = 1'b0;
    case (state)
      S_IDLE: if (req_valid) state_nx = S_RUN;
      S_RUN: begin
        alu_a   = w_a_nib;
        alu_b   = w_b_nib;
        alu_c   = w_arith ? 3'b000 : r_op;
        alu_cin = w_arith ? r_carry : 1'b0;
        if (w_last) state_nx = S_DONE;
      end
      S_DONE: if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_op          <= 3'd0;
      r_a           <= '0;
      r_b           <= '0;
      r_carry       <= 1'b0;
      r_zacc        <= 1'b0;
      resp_result   <= '0;
      resp_carry    <= 1'b0;
      resp_overflow <= 1'b0;
      resp_zero     <= 1'b0;
      resp_flag     <= 1'b0;
    end else if (state == S_IDLE) begin
      if (req_valid) begin
        r_op    <= req_op;
        r_a     <= req_a;
        r_b     <= w_req_inv ? ~req_b : req_b;
        r_carry <= (req_op == 3'b000) ? req_cin : w_req_arith;
        r_cnt   <= '0;
        r_zacc  <= 1'b1;
      end
    end else if (state == S_RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (r_cnt == CW'(i)) resp_result[4*i +: 4] <= alu_result;
      end
      if (w_arith) r_carry <= alu_carry;
      r_zacc <= r_zacc & w_nib_zero;
      if (w_last) begin
        r_cnt         <= '0;
        resp_carry    <= w_arith & alu_carry;
        resp_overflow <= w_arith & alu_overflow;
        resp_zero     <= r_zacc & w_nib_zero;
        case (r_op)
          3'b110:  resp_flag <= alu_result[3] ^ alu_overflow;
          3'b111:  resp_flag <= r_zacc & w_nib_zero;
          default: resp_flag <= 1'b0;
        endcase
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu4_seq_ctrl.sv
//==============================================================================
// tb_alu4_seq_ctrl : directed + random checks of alu4_seq_ctrl against a 16-bit model
// Revision 1.0
//==============================================================================
`default_nettype none

module tb_alu4_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_cin;
  logic [2:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_result;
  logic        resp_carry, resp_overflow, resp_zero, resp_flag;
  logic [3:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_c;
  logic        alu_cin, alu_carry, alu_overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic        ovf;
    logic        zero;
    logic        flag;
  } exp_t;

  logic [2:0]  cur_op;
  logic [15:0] cur_a, cur_b;
  logic        cur_cin;
  exp_t        cur_e;

  always #5 clk = ~clk;

  alu4_seq_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_carry(resp_carry), .resp_overflow(resp_overflow),
    .resp_zero(resp_zero), .resp_flag(resp_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow)
  );

  // 4-bit ALU slice
  always_comb begin
    alu_result   = 4'd0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_c)
      3'b000: begin
        {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      3'b010:  alu_result = ~alu_a;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      default: alu_result = 4'd0;
    endcase
  end

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin);
    exp_t e;
    int ua, ub, sa, sb, s;
    e  = '0;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    case (op)
      3'd0: begin
        s        = sa + sb + int'(cin);
        e.result = 16'(ua + ub + int'(cin));
        e.carry  = (ua + ub + int'(cin)) > 65535;
        e.ovf    = (s > 32767) || (s < -32768);
      end
      3'd1, 3'd6, 3'd7: begin
        s        = sa - sb;
        e.result = 16'(ua - ub);
        e.carry  = (ua >= ub);
        e.ovf    = (s > 32767) || (s < -32768);
        if (op == 3'd6) e.flag = (sa < sb);
        if (op == 3'd7) e.flag = (a == b);
      end
      3'd2:    e.result = ~a;
      3'd3:    e.result = a & b;
      3'd4:    e.result = a | b;
      default: e.result = a ^ b;
    endcase
    e.zero = (e.result == 16'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    cur_op = op; cur_a = a; cur_b = b; cur_cin = cin;
    cur_e  = model(op, a, b, cin);
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("issue_ready", 32'(req_ready), 32'd1);
    set_cur(op, a, b, cin);
    @(posedge clk);
  endtask

  task automatic check_resp(input string tag);
    check({tag, "_result"}, 32'(resp_result), 32'(cur_e.result));
    check({tag, "_carry"},  32'(resp_carry),  32'(cur_e.carry));
    check({tag, "_ovf"},    32'(resp_overflow), 32'(cur_e.ovf));
    check({tag, "_zero"},   32'(resp_zero),   32'(cur_e.zero));
    check({tag, "_flag"},   32'(resp_flag),   32'(cur_e.flag));
  endtask

  // Called just after the accepting edge; returns at the negedge where resp_valid should be up.
  task automatic collect_run(input string tag);
    logic        arith;
    logic [15:0] bp;
    int          mask, low, cin0;
    @(negedge clk);
    req_valid = 1'b0;
    req_a = 16'($urandom); req_b = 16'($urandom); req_op = 3'($urandom); req_cin = 1'($urandom);
    arith = (cur_op == 3'd0) || (cur_op == 3'd1) || (cur_op == 3'd6) || (cur_op == 3'd7);
    bp    = (arith && cur_op != 3'd0) ? ~cur_b : cur_b;
    cin0  = (cur_op == 3'd0) ? int'(cur_cin) : 1;
    for (int i = 0; i < 4; i++) begin
      mask = (1 << (4 * i)) - 1;
      low  = (int'(cur_a) & mask) + (int'(bp) & mask) + cin0;
      check($sformatf("%s_valid_n%0d", tag, i), 32'(resp_valid), 32'd0);
      check($sformatf("%s_ready_n%0d", tag, i), 32'(req_ready), 32'd0);
      check($sformatf("%s_alu_c_n%0d", tag, i), 32'(alu_c), arith ? 32'd0 : 32'(cur_op));
      check($sformatf("%s_alu_a_n%0d", tag, i), 32'(alu_a), 32'((cur_a >> (4 * i)) & 16'hF));
      check($sformatf("%s_alu_b_n%0d", tag, i), 32'(alu_b), 32'((bp >> (4 * i)) & 16'hF));
      check($sformatf("%s_alu_cin_n%0d", tag, i), 32'(alu_cin), arith ? 32'((low >> (4 * i)) & 1) : 32'd0);
      @(negedge clk);
    end
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_alu_idle"}, 32'({alu_a, alu_b, alu_c, alu_cin}), 32'd0);
    check_resp(tag);
  endtask

  task automatic release_resp(input string tag, input int hold);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check_resp({tag, "_hold"});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_rel_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(req_ready), 32'd1);
    check_resp({tag, "_idle"});
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input int hold);
    issue(op, a, b, cin);
    collect_run(tag);
    release_resp(tag, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    exp_t e1;
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'd0; req_a = 16'd0; req_b = 16'd0; req_cin = 1'b0;
    #1;
    check("rst_result", 32'(resp_result), 32'd0);
    check("rst_flags", 32'({resp_carry, resp_overflow, resp_zero, resp_flag}), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_c, alu_cin}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    run_op("add_ripple", 3'd0, 16'h0FFF, 16'h0001, 1'b0, 0);
    run_op("add_ovf",    3'd0, 16'h7FFF, 16'h0001, 1'b0, 0);
    run_op("add_cin",    3'd0, 16'hFFFF, 16'h0000, 1'b1, 1);
    run_op("sub",        3'd1, 16'h0005, 16'h0007, 1'b1, 0);
    run_op("slt_neg",    3'd6, 16'h8000, 16'h0001, 1'b0, 0);
    run_op("slt_ovf",    3'd6, 16'h0001, 16'h8000, 1'b0, 0);
    run_op("eq",         3'd7, 16'h1234, 16'h1234, 1'b0, 0);
    run_op("ne",         3'd7, 16'h1234, 16'h1235, 1'b0, 0);
    run_op("xor",        3'd5, 16'hF0F0, 16'hFFFF, 1'b1, 0);
    run_op("not",        3'd2, 16'h00FF, 16'h1234, 1'b0, 0);
    run_op("and",        3'd3, 16'hA5C3, 16'h0FF0, 1'b0, 0);
    run_op("or",         3'd4, 16'h0000, 16'h0000, 1'b0, 0);

    // backpressure with a second request waiting
    issue(3'd0, 16'h1111, 16'h2222, 1'b0);
    e1 = cur_e;
    collect_run("bp1");
    req_op = 3'd1; req_a = 16'h0100; req_b = 16'h0001; req_cin = 1'b0; req_valid = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_ready", 32'(req_ready), 32'd0);
      check("bp_hold_result", 32'(resp_result), 32'(e1.result));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_rel_valid", 32'(resp_valid), 32'd0);
    check("bp_rel_ready", 32'(req_ready), 32'd1);
    set_cur(3'd1, 16'h0100, 16'h0001, 1'b0);
    @(posedge clk);
    collect_run("bp2");
    release_resp("bp2", 0);

    // reset in the middle of a run
    issue(3'd0, 16'h1111, 16'h1111, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_partial", 32'(resp_result[7:0]), 32'h22);
    rst = 1'b1;
    #1;
    check("mid_rst_result", 32'(resp_result), 32'd0);
    check("mid_rst_flags", 32'({resp_carry, resp_overflow, resp_zero, resp_flag}), 32'd0);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_alu", 32'({alu_a, alu_b, alu_c, alu_cin}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_no_resp", 32'(resp_valid), 32'd0);
    end
    run_op("post_rst", 3'd0, 16'h0001, 16'h0001, 1'b0, 0);

    for (int n = 0; n < 24; n++) begin
      run_op($sformatf("rnd%0d", n), 3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
